// File: rtl/buffer_pkg.sv
// Shared sizing helpers for the buffer family (counter and pointer widths).
// Latency: n/a (compile-time functions only).
// Backpressure: n/a.
package buffer_pkg;

    // Bits needed to hold an occupancy value in 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to address depth entries; never narrower than 1 bit so that
    // a single-entry buffer still has a legal (constant-zero) pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo (max_value+1) up-counter used as a circular-buffer pointer.
// Latency: value updates on the rising edge after inc/clr.
// Backpressure: none; inc is taken every cycle it is high, clr wins over inc.
//
// Ports: clk, rst (async active-low), clr (sync clear), inc (advance),
//        value (current count, 0..max_value).
module wrap_counter
    import buffer_pkg::*;
#(
    parameter int max_value = 3,
    parameter int width     = ptr_width(max_value + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [width-1:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            // With max_value=0 this compare is always true, pinning value at 0.
            value <= (value == width'(max_value)) ? '0 : value + width'(1);
        end
    end

endmodule

// File: rtl/depth_buffer.sv
// Circular FIFO of depth words with occupancy count, almost-full and flush.
// Latency: a word pushed at edge N is presented on dOUT from cycle N+1.
// Backpressure: dInREQ drops when full unless the consumer pops that cycle.
//
// Ports: clk, rst (async active-low), flush (sync clear),
//        producer dInREQ/dInACK/dIN, consumer dOutACK/dOutREQ/dOUT,
//        count (0..depth), almostFull (count >= afull_level).
module depth_buffer
    import buffer_pkg::*;
#(
    parameter int bit_width   = 32,
    parameter int depth       = 4,
    parameter int afull_level = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    output logic                         dInREQ,
    input  logic                         dInACK,
    input  logic [bit_width-1:0]         dIN,
    output logic                         dOutACK,
    input  logic                         dOutREQ,
    output logic [bit_width-1:0]         dOUT,
    output logic [cnt_width(depth)-1:0]  count,
    output logic                         almostFull
);

    localparam int CW = cnt_width(depth);
    localparam int PW = ptr_width(depth);

    logic [bit_width-1:0] storage [depth];
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic                 push;
    logic                 pop;

    // Output-side valid depends on registered state only.
    assign dOutACK = (count != '0);
    assign pop     = dOutACK && dOutREQ;

    // Looking at pop lets a full buffer accept a word in the same cycle the
    // head leaves, keeping full throughput. Held low during flush so no
    // producer word is claimed and then discarded.
    assign dInREQ  = rst && !flush && ((count < CW'(depth)) || pop);
    assign push    = dInACK && dInREQ;

    assign dOUT       = storage[rd_ptr];
    assign almostFull = (count >= CW'(afull_level));

    wrap_counter #(
        .max_value (depth - 1),
        .width     (PW)
    ) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .inc   (push),
        .value (wr_ptr)
    );

    wrap_counter #(
        .max_value (depth - 1),
        .width     (PW)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .inc   (pop),
        .value (rd_ptr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Reset zeroes every entry so dOUT is defined from the first cycle; flush
    // deliberately leaves contents alone since the pointers hide them anyway.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < depth; i++) begin
                storage[i] <= '0;
            end
        end else if (push) begin
            storage[wr_ptr] <= dIN;
        end
    end

endmodule

// File: tb/tb_depth_buffer.sv
module tb_depth_buffer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Three instances: depth 4 (main), depth 1 and depth 3 (non-power-of-two).
    logic [2:0] flush_v = '0;
    logic [2:0] ack_v   = '0;
    logic [2:0] req_v   = '0;
    logic [7:0] din_v [3];
    wire  [2:0] in_req;
    wire  [2:0] out_ack;
    wire  [2:0] afull;
    wire  [7:0] dout [3];
    wire  [2:0] cnt  [3];

    function automatic int dep(input int k);
        return (k == 0) ? 4 : (k == 1) ? 1 : 3;
    endfunction

    function automatic int afl(input int k);
        return (k == 0) ? 3 : (k == 1) ? 1 : 2;
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_dut
        localparam int D  = (i == 0) ? 4 : (i == 1) ? 1 : 3;
        localparam int AF = (i == 0) ? 3 : (i == 1) ? 1 : 2;
        localparam int CW = $clog2(D + 1);
        wire [CW-1:0] c;
        depth_buffer #(
            .bit_width   (8),
            .depth       (D),
            .afull_level (AF)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush_v[i]),
            .dInREQ     (in_req[i]),
            .dInACK     (ack_v[i]),
            .dIN        (din_v[i]),
            .dOutACK    (out_ack[i]),
            .dOutREQ    (req_v[i]),
            .dOUT       (dout[i]),
            .count      (c),
            .almostFull (afull[i])
        );
        assign cnt[i] = 3'(c);
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb [3][$];

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    task automatic drive(input int k, input logic f, input logic a,
                         input logic [7:0] d, input logic r);
        flush_v[k] = f;
        ack_v[k]   = a;
        din_v[k]   = d;
        req_v[k]   = r;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Scoreboard: checks flags against the reference occupancy, compares the
    // head on every pop and queues every accepted word.
    task automatic sb_step();
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                chk("rst_in_req", k, 32'(in_req[k]), 0);
                chk("rst_out_ack", k, 32'(out_ack[k]), 0);
                chk("rst_count", k, 32'(cnt[k]), 0);
                chk("rst_afull", k, 32'(afull[k]), 0);
                chk("rst_dout", k, 32'(dout[k]), 0);
                sb[k].delete();
            end else begin
                int  sz;
                logic mpop, ereq;
                sz   = sb[k].size();
                mpop = (sz != 0) && req_v[k];
                ereq = !flush_v[k] && ((sz < dep(k)) || mpop);
                chk("sb_count", k, 32'(cnt[k]), 32'(sz));
                chk("sb_out_ack", k, 32'(out_ack[k]), 32'(sz != 0));
                chk("sb_afull", k, 32'(afull[k]), 32'(sz >= afl(k)));
                chk("sb_in_req", k, 32'(in_req[k]), 32'(ereq));
                if (mpop) begin
                    chk("sb_dout", k, 32'(dout[k]), 32'(sb[k][0]));
                    void'(sb[k].pop_front());
                end
                if (ack_v[k] && ereq) sb[k].push_back(din_v[k]);
                if (flush_v[k]) sb[k].delete();
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic edge_();
        sb_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        half();
        edge_();
    endtask

    task automatic fill_drain(input int k);
        int d;
        d = dep(k);
        for (int i = 0; i <= d; i++) begin
            drive(k, 1'b0, 1'b1, 8'(8'h11 * (i + 1)), 1'b0);
            half();
            chk("fd_in_req", k, 32'(in_req[k]), 32'(i < d));
            chk("fd_count", k, 32'(cnt[k]), 32'((i < d) ? i : d));
            edge_();
        end
        for (int i = 0; i < d; i++) begin
            drive(k, 1'b0, 1'b0, 8'h00, 1'b1);
            half();
            chk("fd_dout", k, 32'(dout[k]), 32'(8'h11 * (i + 1)));
            edge_();
        end
        drive(k, 1'b0, 1'b0, 8'h00, 1'b0);
        half();
        chk("fd_empty", k, 32'(out_ack[k]), 0);
        edge_();
    endtask

    task automatic throughput(input int k, input int n);
        int d;
        d = dep(k);
        for (int i = 0; i < d; i++) begin
            drive(k, 1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
            cyc();
        end
        for (int j = 0; j < n; j++) begin
            drive(k, 1'b0, 1'b1, 8'(8'h50 + d + j), 1'b1);
            half();
            chk("tp_in_req", k, 32'(in_req[k]), 1);
            chk("tp_count", k, 32'(cnt[k]), 32'(d));
            chk("tp_dout", k, 32'(dout[k]), 32'(8'(8'h50 + j)));
            edge_();
        end
        for (int i = 0; i < d; i++) begin
            drive(k, 1'b0, 1'b0, 8'h00, 1'b1);
            half();
            chk("tp_drain", k, 32'(dout[k]), 32'(8'(8'h50 + n + i)));
            edge_();
        end
        drive(k, 1'b0, 1'b0, 8'h00, 1'b0);
        half();
        chk("tp_empty", k, 32'(cnt[k]), 0);
        edge_();
    endtask

    typedef struct {
        logic       f;
        logic       a;
        logic [7:0] d;
        logic       r;
        logic       e_in_req;
        logic       e_out_ack;
        logic [2:0] e_cnt;
        logic       e_af;
        logic       chk_dout;
        logic [7:0] e_dout;
    } vec_t;

    vec_t tbl [10];

    initial begin
        // Fill/drain on depth 4, afull_level 3; the 0x55 push hits a full
        // buffer and must be refused.
        tbl[0] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 8'h11};
        tbl[2] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 8'h11};
        tbl[3] = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 8'h11};
        tbl[4] = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 8'h11};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 8'h11};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 8'h22};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 8'h33};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 8'h44};
        tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00};

        idle_all();
        cyc();
        half();
        for (int k = 0; k < 3; k++) begin
            chk("reset_in_req", k, 32'(in_req[k]), 0);
            chk("reset_dout", k, 32'(dout[k]), 0);
        end
        edge_();
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(0, tbl[i].f, tbl[i].a, tbl[i].d, tbl[i].r);
            half();
            chk("vec_in_req", 0, 32'(in_req[0]), 32'(tbl[i].e_in_req));
            chk("vec_out_ack", 0, 32'(out_ack[0]), 32'(tbl[i].e_out_ack));
            chk("vec_count", 0, 32'(cnt[0]), 32'(tbl[i].e_cnt));
            chk("vec_afull", 0, 32'(afull[0]), 32'(tbl[i].e_af));
            if (tbl[i].chk_dout) chk("vec_dout", 0, 32'(dout[0]), 32'(tbl[i].e_dout));
            edge_();
        end

        throughput(0, 10);
        for (int k = 1; k < 3; k++) begin
            fill_drain(k);
            throughput(k, 10);
        end

        // Latency: no fall-through when empty.
        drive(0, 1'b0, 1'b1, 8'hA5, 1'b0);
        half();
        chk("lat_ack_n", 0, 32'(out_ack[0]), 0);
        edge_();
        drive(0, 1'b0, 1'b0, 8'h00, 1'b1);
        half();
        chk("lat_ack_n1", 0, 32'(out_ack[0]), 1);
        chk("lat_dout_n1", 0, 32'(dout[0]), 32'h A5);
        edge_();
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc();

        // Flush with a pop and an attempted push in the same cycle.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b0, 1'b1, 8'(8'h61 + i), 1'b0);
            cyc();
        end
        drive(0, 1'b1, 1'b1, 8'h99, 1'b1);
        half();
        chk("fl_in_req", 0, 32'(in_req[0]), 0);
        chk("fl_head", 0, 32'(dout[0]), 32'h61);
        chk("fl_count", 0, 32'(cnt[0]), 3);
        edge_();
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
        half();
        chk("fl_after_count", 0, 32'(cnt[0]), 0);
        chk("fl_after_ack", 0, 32'(out_ack[0]), 0);
        chk("fl_after_req", 0, 32'(in_req[0]), 1);
        edge_();
        drive(0, 1'b0, 1'b1, 8'hC3, 1'b0);
        cyc();
        drive(0, 1'b0, 1'b0, 8'h00, 1'b1);
        half();
        chk("fl_next_word", 0, 32'(dout[0]), 32'hC3);
        edge_();
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc();

        // Asynchronous reset between edges with two words stored.
        drive(0, 1'b0, 1'b1, 8'h31, 1'b0);
        cyc();
        drive(0, 1'b0, 1'b1, 8'h32, 1'b0);
        cyc();
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_count", 0, 32'(cnt[0]), 0);
        chk("ar_out_ack", 0, 32'(out_ack[0]), 0);
        chk("ar_in_req", 0, 32'(in_req[0]), 0);
        chk("ar_dout", 0, 32'(dout[0]), 0);
        cyc();
        rst = 1'b1;
        drive(0, 1'b0, 1'b1, 8'h7E, 1'b0);
        half();
        chk("ar_rel_in_req", 0, 32'(in_req[0]), 1);
        chk("ar_rel_out_ack", 0, 32'(out_ack[0]), 0);
        edge_();
        drive(0, 1'b0, 1'b0, 8'h00, 1'b1);
        half();
        chk("ar_7e_count", 0, 32'(cnt[0]), 1);
        chk("ar_7e_dout", 0, 32'(dout[0]), 32'h7E);
        edge_();
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
        half();
        chk("ar_7e_only", 0, 32'(out_ack[0]), 0);
        edge_();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
